// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, rx FSM states
// and a constant-friendly clog2 helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs,
// with a selectable reset level (idle-high lines reset to 1).
module uart_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: midpoint sampling, glitch-start rejection,
// parity/framing/overrun reporting, valid/ready delivery.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   import uart_pkg::*;

   localparam int SCW  = clog2(OVERSAMPLE);
   localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int BCW  = clog2(MAXB + 1);

   localparam logic [SCW-1:0] MID   = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] LAST  = SCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] NDATA = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] NSTOP = BCW'(STOP_BITS - 1);
   localparam logic           ODD   = (PARITY == PAR_ODD);
   localparam logic           HASP  = (PARITY != PAR_NONE);

   rx_state_e state_q, state_d;
   logic [SCW-1:0] scnt_q, scnt_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic perr_q, perr_d;
   logic ferr_q, ferr_d;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic valid_q, valid_d;
   logic pe_q, pe_d;
   logic fe_q, fe_d;
   logic ovr_q, ovr_d;

   logic rxs;
   logic sample;
   logic done;

   uart_sync2 #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rx),
      .q_o(rxs)
   );

   assign sample = tick && (scnt_q == LAST);

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      bcnt_d  = bcnt_q;
      sh_d    = sh_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done    = 1'b0;

      // bit-period states share one free-running sample counter
      if (tick && (state_q == DATA || state_q == uart_pkg::PARITY ||
                   state_q == STOP)) begin
         scnt_d = sample ? '0 : scnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (tick && !rxs) begin
               state_d = START;
               scnt_d  = '0;
            end
         end
         START: begin
            if (tick) begin
               if (scnt_q == MID) begin
                  scnt_d  = '0;
                  bcnt_d  = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
                  state_d = rxs ? IDLE : DATA;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (sample) begin
               sh_d   = {rxs, sh_q[DATA_BITS-1:1]};
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == NDATA) begin
                  bcnt_d  = '0;
                  state_d = HASP ? uart_pkg::PARITY : STOP;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (sample) begin
               perr_d  = ((^sh_q) ^ rxs) != ODD;
               bcnt_d  = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               ferr_d = ferr_q | ~rxs;
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == NSTOP) begin
                  done    = 1'b1;
                  bcnt_d  = '0;
                  state_d = ferr_d ? WAIT_HIGH : IDLE;
               end
            end
         end
         WAIT_HIGH: begin
            if (tick && rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ovr_d   = 1'b0;
      if (done) begin
         if (!valid_q || rx_ready) begin
            data_d  = sh_q;
            pe_d    = perr_q;
            fe_d    = ferr_d;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         sh_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         sh_q    <= sh_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = pe_q;
   assign frame_err   = fe_q;
   assign overrun_err = ovr_q;
   assign busy        = (state_q != IDLE);

endmodule
